md5_chan_arbiter: RTL and testbench

Multi-channel front-end for the MD5 top level. It grants the single MD5 core to one of `NUM_CH` requesters for a whole message, from the first beat to the `ReqLast` beat. It muxes the granted channel's beats onto the core input bus under `DataBusy` backpressure. It then holds the grant until the 4-word digest has been returned, tagged with the owning channel id.

---
 rtl/md5_arb_pkg.sv | 15 +
 rtl/md5_rr_pick.sv | 47 ++++
 rtl/md5_chan_arbiter.sv | 151 +++++++++++++++
 tb/tb_md5_chan_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_arb_pkg.sv
// Shared types and constants for the MD5 multi-channel front-end arbiter.
package md5_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    XFER      = 2'd1,
    WAIT_DGST = 2'd2
  } arb_state_e;

  localparam int unsigned DGST_WORDS_DEF = 4;
  localparam int unsigned CHAN_W         = 3;
  localparam int unsigned NUMB_W         = 6;
  localparam int unsigned CNT_W          = 2;

endpackage

// File: rtl/md5_rr_pick.sv
// Combinational channel picker: round-robin from ptr, or lowest index wins
// when MD5_ARB_FIXED_PRIO_EN is defined.
module md5_rr_pick
  import md5_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] elig,
  input  logic [CHAN_W-1:0] ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CHAN_W-1:0] gnt_id
);

`ifdef MD5_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Scan downwards so the lowest eligible index is written last.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        gnt_id = CHAN_W'(i);
      end
    end
  end
`else
  // Offset k from ptr maps to channel (ptr+k) mod NUM_CH; smallest offset wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (elig[j] && (((32'(ptr) + 32'(k)) % NUM_CH) == 32'(j))) begin
          gnt    = '0;
          gnt[j] = 1'b1;
          gnt_id = CHAN_W'(j);
        end
      end
    end
  end
`endif

endmodule

// File: rtl/md5_chan_arbiter.sv
// Grants the single MD5 core to one requester channel per message and routes the
// digest back to it. Define MD5_ARB_FIXED_PRIO_EN for fixed-priority arbitration.
module md5_chan_arbiter
  import md5_arb_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DGST_WORDS = DGST_WORDS_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ReqVld,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ReqData,
  input  logic [NUM_CH-1:0]            ReqFirst,
  input  logic [NUM_CH-1:0]            ReqLast,
  input  logic [NUM_CH*NUMB_W-1:0]     ReqNumb,
  input  logic [NUM_CH-1:0]            ReqInitVec,
  output logic [NUM_CH-1:0]            ReqRdy,
  output logic                         DataVld,
  output logic [DATA_WIDTH-1:0]        DataIn,
  output logic                         DataFirst,
  output logic                         DataLast,
  output logic [NUMB_W-1:0]            DataNumb,
  output logic                         InitVec,
  input  logic                         DataBusy,
  input  logic                         MsgDgstVld,
  input  logic [DATA_WIDTH-1:0]        MsgDigest,
  output logic                         DgstVld,
  output logic [DATA_WIDTH-1:0]        DgstData,
  output logic [CHAN_W-1:0]            DgstChan,
  output logic                         DgstLast,
  output logic                         GntVld,
  output logic [CHAN_W-1:0]            GntChan
);

  arb_state_e             state, state_nxt;
  logic [CHAN_W-1:0]      owner, ptr, pick_id;
  logic [CNT_W-1:0]       cnt;
  logic [NUM_CH-1:0]      elig, pick_gnt;
  logic                   pick_any, beat_acc, dgst_last;
  logic                   own_vld, own_first, own_last, own_iv;
  logic [DATA_WIDTH-1:0]  own_data;
  logic [NUMB_W-1:0]      own_numb;

  assign elig     = ReqVld & (ReqFirst | ReqInitVec);
  assign pick_any = |pick_gnt;

  md5_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .elig   (elig),
    .ptr    (ptr),
    .gnt    (pick_gnt),
    .gnt_id (pick_id)
  );

  // Owner's request fields.
  always_comb begin
    own_vld   = 1'b0;
    own_first = 1'b0;
    own_last  = 1'b0;
    own_iv    = 1'b0;
    own_data  = '0;
    own_numb  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (owner == CHAN_W'(i)) begin
        own_vld   = ReqVld[i];
        own_first = ReqFirst[i];
        own_last  = ReqLast[i];
        own_iv    = ReqInitVec[i];
        own_data  = ReqData[i*DATA_WIDTH +: DATA_WIDTH];
        own_numb  = ReqNumb[i*NUMB_W +: NUMB_W];
      end
    end
  end

  assign beat_acc  = (state == XFER) && own_vld && !DataBusy;
  assign dgst_last = (state == WAIT_DGST) && MsgDgstVld && (cnt == CNT_W'(DGST_WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (pick_any) state_nxt = XFER;
      XFER:      if (beat_acc && own_last) state_nxt = WAIT_DGST;
      WAIT_DGST: if (dgst_last) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Owner, digest word counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      if (state == IDLE && pick_any) begin
        owner <= pick_id;
        cnt   <= '0;
      end
      if (state == WAIT_DGST && MsgDgstVld) cnt <= dgst_last ? '0 : CNT_W'(cnt + 1'b1);
`ifdef MD5_ARB_FIXED_PRIO_EN
      ptr <= '0;
`else
      if (dgst_last) ptr <= (owner == CHAN_W'(NUM_CH - 1)) ? '0 : CHAN_W'(owner + 1'b1);
`endif
    end
  end

  always_comb begin
    ReqRdy    = '0;
    DataVld   = 1'b0;
    DataIn    = '0;
    DataFirst = 1'b0;
    DataLast  = 1'b0;
    DataNumb  = '0;
    InitVec   = 1'b0;
    DgstVld   = 1'b0;
    DgstData  = '0;
    DgstChan  = '0;
    DgstLast  = 1'b0;
    GntVld    = (state != IDLE);
    GntChan   = (state != IDLE) ? owner : '0;
    case (state)
      XFER: begin
        for (int i = 0; i < NUM_CH; i++) ReqRdy[i] = !DataBusy && (owner == CHAN_W'(i));
        DataVld = beat_acc;
        if (beat_acc) begin
          DataIn    = own_data;
          DataFirst = own_first;
          DataLast  = own_last;
          DataNumb  = own_numb;
          InitVec   = own_iv;
        end
      end
      WAIT_DGST: begin
        DgstVld = MsgDgstVld;
        if (MsgDgstVld) begin
          DgstData = MsgDigest;
          DgstChan = owner;
          DgstLast = dgst_last;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_md5_chan_arbiter.sv
// Self-checking bench for md5_chan_arbiter: directed scenarios plus random
// multi-channel traffic checked against a message-level arbitration model.
module tb_md5_chan_arbiter;

  localparam int NUM_CH = 4;
  localparam int DW     = 32;
  localparam int DGST   = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_CH-1:0]      req_vld, req_first, req_last, req_iv;
  logic [NUM_CH*DW-1:0]   req_data;
  logic [NUM_CH*6-1:0]    req_numb;
  logic                   data_busy, msg_dgst_vld;
  logic [DW-1:0]          msg_digest;

  logic [NUM_CH-1:0]      ReqRdy;
  logic                   DataVld, DataFirst, DataLast, InitVec;
  logic [DW-1:0]          DataIn, DgstData;
  logic [5:0]             DataNumb;
  logic                   DgstVld, DgstLast, GntVld;
  logic [2:0]             DgstChan, GntChan;

  int n_tests = 0;
  int n_fail  = 0;
  int ptr_m   = 0;

  md5_chan_arbiter #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .DGST_WORDS(DGST)) dut (
    .clk(clk), .rst_n(rst_n),
    .ReqVld(req_vld), .ReqData(req_data), .ReqFirst(req_first), .ReqLast(req_last),
    .ReqNumb(req_numb), .ReqInitVec(req_iv), .ReqRdy(ReqRdy),
    .DataVld(DataVld), .DataIn(DataIn), .DataFirst(DataFirst), .DataLast(DataLast),
    .DataNumb(DataNumb), .InitVec(InitVec), .DataBusy(data_busy),
    .MsgDgstVld(msg_dgst_vld), .MsgDigest(msg_digest),
    .DgstVld(DgstVld), .DgstData(DgstData), .DgstChan(DgstChan), .DgstLast(DgstLast),
    .GntVld(GntVld), .GntChan(GntChan)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Arbitration rule: first requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [NUM_CH-1:0] mask, input int p);
    int c;
    for (int k = 0; k < NUM_CH; k++) begin
`ifdef MD5_ARB_FIXED_PRIO_EN
      c = k;
`else
      c = (p + k) % NUM_CH;
`endif
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [31:0] beat_word(input logic [31:0] base, input int idx);
    return base + 32'(idx) * 32'h9E3779B9;
  endfunction

  function automatic logic [5:0] beat_numb(input logic [31:0] base, input int idx, input int total,
                                           input logic [5:0] numb);
    return (idx == total - 1) ? numb : 6'(base[5:0] + 6'(idx));
  endfunction

  task automatic set_beat(input int ch, input logic [31:0] base, input int idx, input int n_iv,
                          input int total, input logic [5:0] numb);
    req_vld[ch]            = 1'b1;
    req_data[ch*32 +: 32]  = beat_word(base, idx);
    req_iv[ch]             = (idx < n_iv);
    req_first[ch]          = (idx == n_iv);
    req_last[ch]           = (idx == total - 1);
    req_numb[ch*6 +: 6]    = beat_numb(base, idx, total, numb);
  endtask

  task automatic clr_ch(input int ch);
    req_vld[ch] = 1'b0; req_first[ch] = 1'b0; req_last[ch] = 1'b0; req_iv[ch] = 1'b0;
    req_data[ch*32 +: 32] = '0; req_numb[ch*6 +: 6] = '0;
  endtask

  task automatic present_first(input int ch);
    logic iv;
    iv = 1'($urandom_range(0, 1));
    req_vld[ch] = 1'b1; req_iv[ch] = iv; req_first[ch] = !iv;
    req_last[ch] = 1'($urandom_range(0, 1));
    req_data[ch*32 +: 32] = $urandom; req_numb[ch*6 +: 6] = 6'($urandom);
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    for (int c = 0; c < NUM_CH; c++) clr_ch(c);
    data_busy = 1'b0; msg_dgst_vld = 1'b0; msg_digest = '0; ptr_m = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // One whole message from ch: idle cycle, beats with a DataBusy window, digest return.
  // Entered just after a clock edge with the arbiter idle and ch the expected winner.
  task automatic do_msg(input int ch, input int n_iv, input int n_dat, input int busy_at,
                        input int busy_len, input logic [5:0] numb);
    int total, idx, g, k;
    logic [31:0] base, dw;
    logic bsy, dv;
    logic [NUM_CH-1:0] exp_rdy;
    total = n_iv + n_dat; idx = 0; g = 0; k = 0;
    base = $urandom;
    set_beat(ch, base, 0, n_iv, total, numb);
    data_busy = 1'b0; msg_dgst_vld = 1'($urandom_range(0, 1)); msg_digest = $urandom;
    @(negedge clk);
    n_tests++; if (GntVld !== 1'b0) begin n_fail++; $display("FAIL idle_gnt ch%0d: got %b want 0", ch, GntVld); end
    n_tests++; if (ReqRdy !== '0 || DataVld !== 1'b0 || DgstVld !== 1'b0) begin
      n_fail++; $display("FAIL idle_outputs ch%0d: rdy=%b dvld=%b dgst=%b want 0", ch, ReqRdy, DataVld, DgstVld); end
    @(posedge clk); #1;
    while (idx < total && g < total + busy_len + 8) begin
      bsy = (g >= busy_at) && (g < busy_at + busy_len);
      data_busy = bsy;
      set_beat(ch, base, idx, n_iv, total, numb);
      msg_dgst_vld = 1'($urandom_range(0, 1)); msg_digest = $urandom;
      exp_rdy = bsy ? '0 : (NUM_CH'(1) << ch);
      @(negedge clk);
      n_tests++; if (GntVld !== 1'b1 || GntChan !== 3'(ch)) begin
        n_fail++; $display("FAIL xfer_gnt: got vld=%b chan=%0d want 1/%0d", GntVld, GntChan, ch); end
      n_tests++; if (ReqRdy !== exp_rdy || DataVld !== !bsy) begin
        n_fail++; $display("FAIL xfer_rdy ch%0d cyc%0d: rdy=%b dvld=%b want %b/%b", ch, g, ReqRdy, DataVld, exp_rdy, !bsy); end
      n_tests++; if (DgstVld !== 1'b0) begin n_fail++; $display("FAIL stray_dgst_xfer: got %b want 0", DgstVld); end
      n_tests++;
      if (!bsy) begin
        if (DataIn !== beat_word(base, idx) || DataFirst !== (idx == n_iv) || DataLast !== (idx == total - 1) ||
            InitVec !== (idx < n_iv) || DataNumb !== beat_numb(base, idx, total, numb)) begin
          n_fail++; $display("FAIL beat ch%0d idx%0d: got %h f%b l%b iv%b n%0d want %h f%b l%b iv%b n%0d", ch, idx,
            DataIn, DataFirst, DataLast, InitVec, DataNumb, beat_word(base, idx), idx == n_iv, idx == total - 1,
            idx < n_iv, beat_numb(base, idx, total, numb)); end
      end else if (DataIn !== '0 || DataFirst !== 1'b0 || DataLast !== 1'b0 || InitVec !== 1'b0 || DataNumb !== '0) begin
        n_fail++; $display("FAIL busy_zero ch%0d: got %h f%b l%b iv%b n%0d want zeros", ch, DataIn, DataFirst, DataLast, InitVec, DataNumb);
      end
      if (ReqRdy[ch]) idx++;
      g++;
      @(posedge clk); #1;
    end
    n_tests++; if (idx != total || g != total + busy_len) begin
      n_fail++; $display("FAIL beat_count ch%0d: got %0d beats in %0d cycles want %0d in %0d", ch, idx, g, total, total + busy_len); end
    clr_ch(ch);
    g = 0;
    while (k < DGST && g < 40) begin
      dv = ($urandom_range(0, 3) != 0); dw = $urandom;
      msg_dgst_vld = dv; msg_digest = dw; data_busy = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_tests++; if (GntVld !== 1'b1 || GntChan !== 3'(ch) || ReqRdy !== '0 || DataVld !== 1'b0) begin
        n_fail++; $display("FAIL wait_state ch%0d: gnt=%b/%0d rdy=%b dvld=%b want 1/%0d/0/0", ch, GntVld, GntChan, ReqRdy, DataVld, ch); end
      n_tests++; if (DgstVld !== dv) begin n_fail++; $display("FAIL dgst_vld: got %b want %b", DgstVld, dv); end
      if (dv) begin
        n_tests++; if (DgstData !== dw || DgstChan !== 3'(ch) || DgstLast !== (k == DGST - 1)) begin
          n_fail++; $display("FAIL dgst_word%0d: got %h ch%0d last%b want %h ch%0d last%b", k, DgstData, DgstChan, DgstLast, dw, ch, k == DGST - 1); end
        k++;
      end
      g++;
      @(posedge clk); #1;
    end
    n_tests++; if (k != DGST) begin n_fail++; $display("FAIL dgst_timeout ch%0d: got %0d words want %0d", ch, k, DGST); end
    msg_dgst_vld = 1'b0; data_busy = 1'b0;
`ifdef MD5_ARB_FIXED_PRIO_EN
    ptr_m = 0;
`else
    ptr_m = (ch + 1) % NUM_CH;
`endif
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int c = 0; c < NUM_CH; c++) clr_ch(c);
    present_first(0);
    data_busy = 1'b0; msg_dgst_vld = 1'b1; msg_digest = 32'hDEADBEEF;
    @(negedge clk); @(negedge clk);
    n_tests++; if (ReqRdy !== '0 || GntVld !== 1'b0 || GntChan !== '0) begin
      n_fail++; $display("FAIL reset_gnt: rdy=%b gnt=%b/%0d want 0", ReqRdy, GntVld, GntChan); end
    n_tests++; if (DataVld !== 1'b0 || DataIn !== '0 || DataFirst !== 1'b0 || DataLast !== 1'b0 || DataNumb !== '0 || InitVec !== 1'b0) begin
      n_fail++; $display("FAIL reset_core: vld=%b in=%h want 0", DataVld, DataIn); end
    n_tests++; if (DgstVld !== 1'b0 || DgstData !== '0 || DgstChan !== '0 || DgstLast !== 1'b0) begin
      n_fail++; $display("FAIL reset_dgst: vld=%b data=%h want 0", DgstVld, DgstData); end
    rst_n = 1'b1; clr_ch(0); msg_dgst_vld = 1'b0;
    ptr_m = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_channel;
    do_msg(2, 4, 16, 0, 0, 6'd32);
    @(negedge clk);
    n_tests++; if (GntVld !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b want 0", GntVld); end
    @(posedge clk); #1;
  endtask

  task automatic test_contention;
    logic [NUM_CH-1:0] pend;
    int w;
    apply_reset();
    pend = 4'b1011;
    for (int c = 0; c < NUM_CH; c++) if (pend[c]) present_first(c);
    for (int r = 0; r < 3; r++) begin
      w = model_pick(pend, ptr_m);
      do_msg(w, 0, $urandom_range(1, 3), 0, 0, 6'($urandom_range(1, 32)));
      pend[w] = 1'b0;
    end
    pend = 4'b0101;
    present_first(0); present_first(2);
    for (int r = 0; r < 2; r++) begin
      w = model_pick(pend, ptr_m);
      do_msg(w, 0, 2, 0, 0, 6'd16);
      pend[w] = 1'b0;
    end
  endtask

  task automatic test_backpressure;
    do_msg(1, 0, 10, 4, 3, 6'd20);
    do_msg(3, 2, 5, 0, 2, 6'd1);
  endtask

  task automatic test_stray;
    msg_dgst_vld = 1'b1; msg_digest = 32'h12345678;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++; if (DgstVld !== 1'b0 || GntVld !== 1'b0) begin
        n_fail++; $display("FAIL stray_idle_dgst: dgst=%b gnt=%b want 0", DgstVld, GntVld); end
      @(posedge clk); #1;
    end
    msg_dgst_vld = 1'b0;
    req_vld[1] = 1'b1; req_first[1] = 1'b0; req_iv[1] = 1'b0; req_last[1] = 1'b1; req_data[32 +: 32] = 32'hCAFEF00D;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++; if (GntVld !== 1'b0 || ReqRdy !== '0) begin
        n_fail++; $display("FAIL nonfirst_idle: gnt=%b rdy=%b want 0", GntVld, ReqRdy); end
      @(posedge clk); #1;
    end
    do_msg(0, 0, 3, 1, 1, 6'd7);
    @(negedge clk);
    n_tests++; if (GntVld !== 1'b0 || ReqRdy[1] !== 1'b0) begin
      n_fail++; $display("FAIL nonfirst_after: gnt=%b rdy1=%b want 0", GntVld, ReqRdy[1]); end
    @(posedge clk); #1;
    clr_ch(1);
  endtask

  task automatic test_reset_mid_xfer;
    logic [31:0] base;
    logic [NUM_CH-1:0] pend;
    int idx, cyc, w;
    do_msg(1, 0, 2, 0, 0, 6'd8);
    base = $urandom; idx = 0; cyc = 0; data_busy = 1'b0;
    while (idx < 7 && cyc < 30) begin
      set_beat(0, base, idx, 0, 10, 6'd12);
      @(negedge clk);
      if (ReqRdy[0]) idx++;
      cyc++;
      @(posedge clk); #1;
    end
    n_tests++; if (idx != 7 || GntVld !== 1'b1) begin
      n_fail++; $display("FAIL partial_msg: got %0d beats gnt=%b want 7/1", idx, GntVld); end
    set_beat(0, base, 7, 0, 10, 6'd12);
    msg_dgst_vld = 1'b1; msg_digest = $urandom;
    rst_n = 1'b0;
    #1;
    n_tests++; if (ReqRdy !== '0 || GntVld !== 1'b0 || GntChan !== '0) begin
      n_fail++; $display("FAIL midrst_gnt: rdy=%b gnt=%b/%0d want 0", ReqRdy, GntVld, GntChan); end
    n_tests++; if (DataVld !== 1'b0 || DataIn !== '0 || DataFirst !== 1'b0 || DataLast !== 1'b0 || DataNumb !== '0 || InitVec !== 1'b0) begin
      n_fail++; $display("FAIL midrst_core: vld=%b in=%h want 0", DataVld, DataIn); end
    n_tests++; if (DgstVld !== 1'b0 || DgstData !== '0 || DgstChan !== '0 || DgstLast !== 1'b0) begin
      n_fail++; $display("FAIL midrst_dgst: vld=%b data=%h want 0", DgstVld, DgstData); end
    ptr_m = 0;
    @(negedge clk);
    rst_n = 1'b1; clr_ch(0); msg_dgst_vld = 1'b0;
    @(posedge clk); #1;
    pend = 4'b1010;
    present_first(1); present_first(3);
    for (int r = 0; r < 2; r++) begin
      w = model_pick(pend, ptr_m);
      do_msg(w, 0, 3, 1, 1, 6'd5);
      pend[w] = 1'b0;
    end
  endtask

  task automatic test_random_traffic;
    logic [NUM_CH-1:0] pend;
    int w, n_iv, n_dat, total, b_at, b_len;
    pend = '0;
    for (int m = 0; m < 25; m++) begin
      for (int c = 0; c < NUM_CH; c++)
        if (!pend[c] && $urandom_range(0, 1) == 1) begin present_first(c); pend[c] = 1'b1; end
      if (pend == '0) begin w = $urandom_range(0, NUM_CH - 1); present_first(w); pend[w] = 1'b1; end
      w = model_pick(pend, ptr_m);
      n_iv  = $urandom_range(0, 4);
      n_dat = $urandom_range(1, 6);
      total = n_iv + n_dat;
      b_at  = $urandom_range(0, total - 1);
      b_len = $urandom_range(0, 3);
      do_msg(w, n_iv, n_dat, b_at, b_len, 6'($urandom_range(1, 32)));
      pend[w] = 1'b0;
    end
    for (int c = 0; c < NUM_CH; c++) clr_ch(c);
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_contention();
    test_backpressure();
    test_stray();
    test_reset_mid_xfer();
    test_random_traffic();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
